alu_packet_ctrl: RTL and testbench

Packet-level controller between the UART byte stream and the 32-bit ALU datapath on the iCEBreaker build. It parses command packets from the UART receiver and either echoes the payload or folds the 32-bit operands through the shared ALU unit. For arithmetic commands it serialises the 32-bit result back to the UART transmitter. It owns all sequencing; the ALU unit and UART cores stay stateless with respect to packets.

---
 rtl/alu_ctrl_pkg.sv | 44 ++++
 rtl/alu_ctrl_serdes.sv | 57 +++++
 rtl/alu_packet_ctrl.sv | 161 ++++++++++++++++
 tb/tb_alu_packet_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants, types and opcode helpers for the UART packet / ALU controller.
package alu_ctrl_pkg;

  localparam int unsigned HdrBytes = 4;
  localparam int unsigned OpBytes  = 4;

  localparam logic [7:0] OpcEcho = 8'hEC;
  localparam logic [7:0] OpcAdd  = 8'h8A;
  localparam logic [7:0] OpcMul  = 8'h8B;
  localparam logic [7:0] OpcDiv  = 8'h8C;

  typedef enum logic [1:0] {
    AluAdd = 2'd0,
    AluMul = 2'd1,
    AluDiv = 2'd2
  } alu_op_e;

  typedef enum logic [3:0] {
    StHdrOp,
    StHdrRsv,
    StHdrLenLo,
    StHdrLenHi,
    StEcho,
    StLoadA,
    StLoadB,
    StIssue,
    StWait,
    StSend,
    StDrain
  } state_e;

  function automatic logic is_arith(input logic [7:0] opc);
    return (opc == OpcAdd) || (opc == OpcMul) || (opc == OpcDiv);
  endfunction

  function automatic alu_op_e opc_to_alu(input logic [7:0] opc);
    case (opc)
      OpcMul:  return AluMul;
      OpcDiv:  return AluDiv;
      default: return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl_serdes.sv
// Word shift register: assembles operands from bytes (LSB first) and unloads a
// parallel-loaded result byte by byte, tracking the byte index within the word.
module alu_ctrl_serdes #(
  parameter int unsigned Width = 32,
  parameter int unsigned ByteW = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] par_i,
  input  logic             shift_in_i,
  input  logic [ByteW-1:0] byte_i,
  input  logic             shift_out_i,
  output logic [Width-1:0] word_o,
  output logic [ByteW-1:0] byte_o,
  output logic             last_o
);

  localparam int unsigned NumBytes = Width / ByteW;
  localparam int unsigned IdxW     = $clog2(NumBytes);

  logic [Width-1:0] sr_q, sr_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (load_i) begin
      sr_d  = par_i;
      idx_d = '0;
    end else if (shift_in_i) begin
      sr_d  = {byte_i, sr_q[Width-1:ByteW]};
      idx_d = idx_q + 1'b1;
    end else if (shift_out_i) begin
      sr_d  = {{ByteW{1'b0}}, sr_q[Width-1:ByteW]};
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  assign word_o = sr_q;
  assign byte_o = sr_q[ByteW-1:0];
  assign last_o = (idx_q == IdxW'(NumBytes - 1));

endmodule

// File: rtl/alu_packet_ctrl.sv
// Packet controller between the UART byte stream and the shared ALU: parses headers,
// echoes payloads or left-folds 32-bit operands through the ALU and sends the result.
module alu_packet_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned datawidth_p = 8,
  parameter int unsigned opwidth_p   = 32,
  parameter int unsigned lenwidth_p  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [datawidth_p-1:0] rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [datawidth_p-1:0] tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [1:0]             alu_op_o,
  output logic [opwidth_p-1:0]   alu_a_o,
  output logic [opwidth_p-1:0]   alu_b_o,
  output logic                   alu_valid_o,
  input  logic                   alu_ready_i,
  input  logic [opwidth_p-1:0]   alu_result_i,
  input  logic                   alu_result_valid_i,
  output logic                   err_o,
  output logic                   busy_o
);

  localparam logic [lenwidth_p-1:0] HdrLen      = lenwidth_p'(HdrBytes);
  localparam logic [lenwidth_p-1:0] MinArithLen = lenwidth_p'(HdrBytes + 2 * OpBytes);

  state_e                 state_q;
  logic                   run_q, err_q;
  logic [datawidth_p-1:0] opc_q, len_lo_q;
  alu_op_e                alu_op_q;
  logic [lenwidth_p-1:0]  rem_q;
  logic [opwidth_p-1:0]   acc_q;

  logic [opwidth_p-1:0]   sd_word;
  logic [datawidth_p-1:0] sd_byte;
  logic                   sd_last, sd_clr, sd_load, sd_shift_in, sd_shift_out;
  logic                   rx_fire, tx_fire;
  logic [lenwidth_p-1:0]  len_w, payload;

  assign len_w   = lenwidth_p'({rx_data_i, len_lo_q});
  assign payload = len_w - HdrLen;

  // run_q keeps rx_ready_o low while in reset and for the first cycle after it.
  always_comb begin
    rx_ready_o = 1'b0;
    tx_valid_o = 1'b0;
    tx_data_o  = sd_byte;
    unique case (state_q)
      StHdrOp, StHdrRsv, StHdrLenLo, StHdrLenHi, StLoadA, StLoadB, StDrain: rx_ready_o = run_q;
      StEcho: begin
        rx_ready_o = tx_ready_i;
        tx_valid_o = rx_valid_i;
        tx_data_o  = rx_data_i;
      end
      StSend:  tx_valid_o = 1'b1;
      default: ;
    endcase
  end

  assign rx_fire      = rx_valid_i & rx_ready_o;
  assign tx_fire      = tx_valid_o & tx_ready_i;
  assign sd_clr       = rx_fire && (state_q == StHdrLenHi);
  assign sd_load      = alu_result_valid_i && (state_q == StWait);
  assign sd_shift_in  = rx_fire && ((state_q == StLoadA) || (state_q == StLoadB));
  assign sd_shift_out = tx_fire && (state_q == StSend);

  alu_ctrl_serdes #(
    .Width (opwidth_p),
    .ByteW (datawidth_p)
  ) u_serdes (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (sd_clr),
    .load_i      (sd_load),
    .par_i       (alu_result_i),
    .shift_in_i  (sd_shift_in),
    .byte_i      (rx_data_i),
    .shift_out_i (sd_shift_out),
    .word_o      (sd_word),
    .byte_o      (sd_byte),
    .last_o      (sd_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StHdrOp;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
      opc_q    <= '0;
      len_lo_q <= '0;
      alu_op_q <= AluAdd;
      rem_q    <= '0;
      acc_q    <= '0;
    end else begin
      run_q <= 1'b1;
      err_q <= 1'b0;
      unique case (state_q)
        StHdrOp: if (rx_fire) begin
          opc_q   <= rx_data_i;
          state_q <= StHdrRsv;
        end
        StHdrRsv: if (rx_fire) state_q <= StHdrLenLo;
        StHdrLenLo: if (rx_fire) begin
          len_lo_q <= rx_data_i;
          state_q  <= StHdrLenHi;
        end
        StHdrLenHi: if (rx_fire) begin
          rem_q <= payload;
          if (len_w < HdrLen) begin
            err_q   <= 1'b1;
            state_q <= StHdrOp;
          end else if (opc_q == OpcEcho) begin
            state_q <= (payload == '0) ? StHdrOp : StEcho;
          end else if (is_arith(opc_q) && (len_w >= MinArithLen) &&
                       ((payload % lenwidth_p'(OpBytes)) == '0)) begin
            alu_op_q <= opc_to_alu(opc_q);
            state_q  <= StLoadA;
          end else begin
            err_q   <= 1'b1;
            state_q <= (payload == '0) ? StHdrOp : StDrain;
          end
        end
        StEcho, StDrain: if (rx_fire) begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == lenwidth_p'(1)) state_q <= StHdrOp;
        end
        StLoadA: if (rx_fire) begin
          rem_q <= rem_q - 1'b1;
          if (sd_last) begin
            acc_q   <= {rx_data_i, sd_word[opwidth_p-1:datawidth_p]};
            state_q <= StLoadB;
          end
        end
        StLoadB: if (rx_fire) begin
          rem_q <= rem_q - 1'b1;
          if (sd_last) state_q <= StIssue;
        end
        StIssue: if (alu_ready_i) state_q <= StWait;
        StWait: if (alu_result_valid_i) begin
          acc_q   <= alu_result_i;
          state_q <= (rem_q == '0) ? StSend : StLoadB;
        end
        StSend: if (tx_fire && sd_last) state_q <= StHdrOp;
        default: state_q <= StHdrOp;
      endcase
    end
  end

  assign alu_valid_o = (state_q == StIssue);
  assign alu_a_o     = acc_q;
  assign alu_b_o     = sd_word;
  assign alu_op_o    = alu_op_q;
  assign err_o       = err_q;
  assign busy_o      = (state_q != StHdrOp);

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Scoreboard bench for alu_packet_ctrl: a packet-level model predicts tx bytes, ALU
// requests and error pulses; an independent monitor pops and compares DUT activity.
module tb_alu_packet_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        alu_valid_o;
  logic        alu_ready_i;
  logic [31:0] alu_result_i;
  logic        alu_result_valid_i;
  logic        err_o;
  logic        busy_o;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } iss_t;

  logic [7:0]  tx_q[$];
  iss_t        iss_q[$];
  logic [7:0]  pl_q[$];
  int          checks = 0;
  int          errors = 0;
  int          err_cnt = 0;
  int          err_exp = 0;
  bit          txr_toggle = 1'b0;
  bit          echo_mode = 1'b0;
  bit          echo_chk = 1'b0;
  bit          hold_res = 1'b0;
  bit          alu_override = 1'b0;
  bit          res_pend = 1'b0;
  int unsigned res_delay = 0;
  logic [31:0] res_val = '0;

  always #5 clk_i = ~clk_i;

  alu_packet_ctrl dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .rx_data_i          (rx_data_i),
    .rx_valid_i         (rx_valid_i),
    .rx_ready_o         (rx_ready_o),
    .tx_data_o          (tx_data_o),
    .tx_valid_o         (tx_valid_o),
    .tx_ready_i         (tx_ready_i),
    .alu_op_o           (alu_op_o),
    .alu_a_o            (alu_a_o),
    .alu_b_o            (alu_b_o),
    .alu_valid_o        (alu_valid_o),
    .alu_ready_i        (alu_ready_i),
    .alu_result_i       (alu_result_i),
    .alu_result_valid_i (alu_result_valid_i),
    .err_o              (err_o),
    .busy_o             (busy_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h expected nothing", name, act);
  endtask

  function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a * b;
      default: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
    endcase
  endfunction

  function automatic logic [1:0] op_of(input logic [7:0] opc);
    if (opc == 8'h8B) return 2'd1;
    if (opc == 8'h8C) return 2'd2;
    return 2'd0;
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) pl_q.push_back(w[8*k +: 8]);
  endtask

  task automatic fill_rand(input int unsigned n);
    pl_q.delete();
    for (int k = 0; k < int'(n); k++) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte has been accepted.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    do begin
      @(negedge clk_i);
      if (echo_chk) check("echo_rx_ready", rx_ready_o, tx_ready_i);
      n++;
    end while (!rx_ready_o && n < 2000);
    if (!rx_ready_o) fail_msg("rx_timeout", b);
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic do_packet(input logic [7:0] opc, input logic [15:0] len, input bit keep_out);
    int unsigned plen;
    bit          arith;
    logic [31:0] acc;
    logic [31:0] opnd;
    plen  = (len >= 16'd4) ? 32'(len) - 4 : 0;
    arith = (opc == 8'h8A) || (opc == 8'h8B) || (opc == 8'h8C);
    if (len < 16'd4) begin
      err_exp++;
    end else if (opc == 8'hEC) begin
      for (int i = 0; i < int'(plen); i++) tx_q.push_back(pl_q[i]);
    end else if (arith && len >= 16'd12 && (len % 16'd4) == 16'd0) begin
      acc = {pl_q[3], pl_q[2], pl_q[1], pl_q[0]};
      for (int i = 1; i < int'(plen / 4); i++) begin
        opnd = {pl_q[4*i+3], pl_q[4*i+2], pl_q[4*i+1], pl_q[4*i]};
        iss_q.push_back('{op: op_of(opc), a: acc, b: opnd});
        acc = alu_fn(op_of(opc), acc, opnd);
      end
      if (keep_out) for (int k = 0; k < 4; k++) tx_q.push_back(acc[8*k +: 8]);
    end else begin
      err_exp++;
    end
    send_byte(opc);
    send_byte(8'($urandom_range(0, 255)));
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    echo_chk = echo_mode && (opc == 8'hEC);
    for (int i = 0; i < int'(plen); i++) send_byte(pl_q[i]);
    echo_chk = 1'b0;
  endtask

  task automatic finish_packet();
    int n;
    n = 0;
    repeat (2) @(posedge clk_i);
    while (busy_o && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (busy_o) fail_msg("idle_timeout", 32'(n));
    @(posedge clk_i);
    #1;
    check("err_count", err_cnt, err_exp);
    check("tx_left", tx_q.size(), 0);
    check("issue_left", iss_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, rx_ready_o, 0);
    check({tag, "_tx_valid"}, tx_valid_o, 0);
    check({tag, "_alu_valid"}, alu_valid_o, 0);
    check({tag, "_err"}, err_o, 0);
    check({tag, "_busy"}, busy_o, 0);
  endtask

  initial begin : tx_drv
    tx_ready_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      tx_ready_i = txr_toggle ? ~tx_ready_i : ($urandom_range(0, 3) != 0);
    end
  end

  // Behavioural ALU: accepts with random readiness, answers after a random delay.
  initial begin : alu_drv
    alu_ready_i        = 1'b0;
    alu_result_valid_i = 1'b0;
    alu_result_i       = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!alu_override) begin
        alu_result_valid_i = 1'b0;
        alu_result_i       = $urandom;
        if (res_pend && !hold_res) begin
          if (res_delay == 0) begin
            alu_result_valid_i = 1'b1;
            alu_result_i       = res_val;
            res_pend           = 1'b0;
          end else begin
            res_delay--;
          end
        end
        alu_ready_i = !res_pend && ($urandom_range(0, 2) != 0);
      end
    end
  end

  initial begin : monitor
    logic err_prev;
    iss_t e;
    err_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        err_prev = 1'b0;
      end else begin
        if (tx_valid_o && tx_ready_i) begin
          if (tx_q.size() == 0) fail_msg("tx_unexpected", tx_data_o);
          else check("tx_byte", tx_data_o, tx_q.pop_front());
        end
        if (alu_valid_o && alu_ready_i) begin
          if (iss_q.size() == 0) begin
            fail_msg("alu_unexpected", alu_a_o);
          end else begin
            e = iss_q.pop_front();
            check("alu_op", alu_op_o, e.op);
            check("alu_a", alu_a_o, e.a);
            check("alu_b", alu_b_o, e.b);
          end
          res_pend  = 1'b1;
          res_val   = alu_fn(alu_op_o, alu_a_o, alu_b_o);
          res_delay = $urandom_range(0, 3);
        end
        if (err_o) begin
          err_cnt++;
          if (err_prev) fail_msg("err_pulse_width", 32'd1);
        end
        err_prev = err_o;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int n;
    logic [7:0]  opc;
    logic [15:0] len;
    int unsigned kind;
    rst_ni     = 1'b1;
    rx_valid_i = 1'b0;
    rx_data_i  = '0;
    #1 rst_ni = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk_i);
    #2 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rx_ready_after_reset", rx_ready_o, 1);

    pl_q.delete(); push_word(32'd1); push_word(32'd2);
    do_packet(8'h8A, 16'd12, 1'b1); finish_packet();

    pl_q.delete(); push_word(32'd2); push_word(32'd3); push_word(32'd4);
    do_packet(8'h8B, 16'd16, 1'b1); finish_packet();

    pl_q.delete(); pl_q.push_back(8'h41); pl_q.push_back(8'h42); pl_q.push_back(8'h43);
    txr_toggle = 1'b1; echo_mode = 1'b1;
    do_packet(8'hEC, 16'd7, 1'b1); finish_packet();
    txr_toggle = 1'b0; echo_mode = 1'b0;

    fill_rand(6);
    do_packet(8'h8A, 16'd10, 1'b1); finish_packet();
    pl_q.delete(); push_word(32'hFFFF_FFFF); push_word(32'd2);
    do_packet(8'h8A, 16'd12, 1'b1); finish_packet();

    fill_rand(4);
    do_packet(8'h55, 16'd8, 1'b1); finish_packet();
    check("busy_after_invalid", busy_o, 0);

    pl_q.delete();
    do_packet(8'h8A, 16'd2, 1'b1); finish_packet();
    do_packet(8'hEC, 16'd4, 1'b1); finish_packet();

    pl_q.delete(); push_word(32'd100); push_word(32'd0); push_word(32'd7);
    do_packet(8'h8C, 16'd16, 1'b1); finish_packet();

    // Park the DUT in WAIT with a result pending, then reset it.
    hold_res = 1'b1;
    pl_q.delete(); push_word(32'd5); push_word(32'd7);
    do_packet(8'h8A, 16'd12, 1'b0);
    n = 0;
    while (iss_q.size() != 0 && n < 1000) begin
      @(negedge clk_i);
      n++;
    end
    check("wait_issue_seen", iss_q.size(), 0);
    repeat (2) @(posedge clk_i);
    #3;
    check("busy_in_wait", busy_o, 1);
    alu_override       = 1'b1;
    alu_result_valid_i = 1'b1;
    alu_result_i       = 32'hDEAD_BEEF;
    rst_ni             = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk_i);
    #2;
    alu_result_valid_i = 1'b0;
    res_pend           = 1'b0;
    hold_res           = 1'b0;
    alu_override       = 1'b0;
    rst_ni             = 1'b1;
    @(posedge clk_i);
    #1;
    pl_q.delete(); push_word(32'h0000_1234); push_word(32'h0001_0000);
    do_packet(8'h8A, 16'd12, 1'b1); finish_packet();

    for (int p = 0; p < 40; p++) begin
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        opc = 8'hEC;
        len = 16'($urandom_range(4, 12));
      end else if (kind <= 3) begin
        opc = 8'h8A + 8'($urandom_range(0, 2));
        len = 16'(4 + 4 * $urandom_range(2, 4));
      end else if (kind == 4) begin
        opc = 8'h8A + 8'($urandom_range(0, 2));
        len = 16'($urandom_range(0, 15));
        if (len >= 16'd12 && len[1:0] == 2'b00) len = len + 16'd1;
      end else begin
        opc = 8'($urandom_range(0, 255));
        if (opc == 8'hEC || opc == 8'h8A || opc == 8'h8B || opc == 8'h8C) opc = 8'h55;
        len = 16'($urandom_range(0, 10));
      end
      fill_rand((len >= 16'd4) ? 32'(len) - 4 : 0);
      do_packet(opc, len, 1'b1);
      finish_packet();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
